// File: rtl/adc_responder_pkg.sv
// Shared definitions for the ADC responder: sample width and FSM state encoding.
package adc_responder_pkg;

  localparam int unsigned ADC_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TICK = 3'd1,
    ST_CONVST    = 3'd2,
    ST_WAIT_HI   = 3'd3,
    ST_WAIT_LO   = 3'd4,
    ST_LATCH     = 3'd5,
    ST_ABORT     = 3'd6
  } state_e;

endpackage

// File: rtl/tick_gen.sv
// Rate divider: tick pulses every DIV cycles while en is held; restarts from zero whenever en drops.
module tick_gen #(
  parameter int unsigned DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!en) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/adc_responder.sv
// ADC side of the req/rdy/dat sample handshake: paces convst/busy conversions while req is held
// and presents each result on dat with a single-cycle rdy pulse.
module adc_responder
  import adc_responder_pkg::*;
#(
  parameter int unsigned WIDTH        = ADC_W,
  parameter int unsigned DIV          = 16,
  parameter int unsigned CONV_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  output logic             rdy,
  output logic [WIDTH-1:0] dat,
  output logic             adc_convst,
  input  logic             adc_busy,
  input  logic [WIDTH-1:0] adc_data,
  output logic             err,
  output logic [15:0]      nsamp
);

  localparam int unsigned TW = $clog2(CONV_TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(CONV_TIMEOUT - 1);

  state_e        state;
  logic [TW-1:0] timer;
  logic          tick;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .en    (req),
    .tick  (tick)
  );

  // Outputs are registered on entry to the state they belong to, so rdy/dat are
  // visible during LATCH and adc_convst during CONVST; the sample is kept or
  // dropped according to req on the edge that sees busy fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      rdy        <= 1'b0;
      dat        <= '0;
      adc_convst <= 1'b0;
      err        <= 1'b0;
      nsamp      <= '0;
      timer      <= '0;
    end else begin
      rdy        <= 1'b0;
      adc_convst <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) state <= ST_WAIT_TICK;
        end
        ST_WAIT_TICK: begin
          if (!req) begin
            state <= ST_IDLE;
          end else if (tick) begin
            state      <= ST_CONVST;
            adc_convst <= 1'b1;
          end
        end
        ST_CONVST: begin
          state <= ST_WAIT_HI;
          timer <= '0;
        end
        // Busy edges are tested before the timeout so an edge on the last cycle still counts.
        ST_WAIT_HI: begin
          if (adc_busy) begin
            state <= ST_WAIT_LO;
            timer <= '0;
          end else if (timer == T_LAST) begin
            state <= ST_ABORT;
            err   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_WAIT_LO: begin
          if (!adc_busy) begin
            state <= ST_LATCH;
            if (req) begin
              dat   <= adc_data;
              rdy   <= 1'b1;
              nsamp <= nsamp + 16'd1;
            end
          end else if (timer == T_LAST) begin
            state <= ST_ABORT;
            err   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_LATCH, ST_ABORT: begin
          state <= req ? ST_WAIT_TICK : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_responder.sv
// Scoreboard bench for adc_responder: an ADC model answers convst, a reference model
// predicts each delivered sample, and a monitor checks rdy/dat/nsamp/convst/err every cycle.
module tb_adc_responder;

  localparam int DIV = 16;
  localparam int TO  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        rdy;
  logic [7:0]  dat;
  logic        adc_convst;
  logic        adc_busy;
  logic [7:0]  adc_data;
  logic        err;
  logic [15:0] nsamp;

  adc_responder #(.WIDTH(8), .DIV(DIV), .CONV_TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .rdy        (rdy),
    .dat        (dat),
    .adc_convst (adc_convst),
    .adc_busy   (adc_busy),
    .adc_data   (adc_data),
    .err        (err),
    .nsamp      (nsamp)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Reference model state
  typedef struct {
    logic [7:0]  d;
    logic [15:0] n;
    int          at;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          rise = 0;
  bit          req_q = 1'b0;
  bit          req_e = 1'b0;
  int          delay_cfg = 2;
  int          len_cfg = 5;
  bit          never = 1'b0;
  bit          active = 1'b0;
  bit          live = 1'b0;
  int          k = 0;
  int          seq_idx = 0;
  logic [7:0]  seq [6] = '{8'h00, 8'h0A, 8'h99, 8'h9B, 8'h93, 8'hD5};
  logic [7:0]  cur_data = 8'h00;
  logic [15:0] nsamp_model = 16'h0000;
  bit          err_exp = 1'b0;

  // ADC model plus expectation generator, evaluated on each rising edge.
  initial begin
    adc_busy <= 1'b0;
    adc_data <= 8'h00;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        rise = cyc + 1;
        live = 1'b0;
        q.delete();
        nsamp_model = 16'h0000;
        err_exp = 1'b0;
      end else if (req && !req_q) begin
        rise = cyc;
      end
      req_q = req;
      req_e = req && !reset;

      if (adc_convst) begin
        active = 1'b1;
        k = 0;
        live = !reset;
      end else if (active) begin
        k++;
      end

      if (active && !never) begin
        if (k == delay_cfg - 1) adc_busy <= 1'b1;
        if (k == delay_cfg + len_cfg - 1) begin
          cur_data = (seq_idx < 6) ? seq[seq_idx] : 8'($urandom);
          seq_idx++;
          adc_busy <= 1'b0;
          adc_data <= cur_data;
        end
        if (k == delay_cfg + len_cfg) begin
          active = 1'b0;
          if (live && !reset && req) begin
            nsamp_model = nsamp_model + 16'd1;
            q.push_back('{cur_data, nsamp_model, cyc});
          end
          live = 1'b0;
        end
      end else if (active && never && live && !reset && k == TO) begin
        err_exp = 1'b1;
        live = 1'b0;
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard and protocol rules.
  int rdy_cnt = 0;
  int convst_cnt = 0;
  int last_rdy = 0;
  int gap = 0;
  bit rdy_prev = 1'b0;

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0 && q[0].at < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_rdy: got no rdy, want dat %0h in cycle %0d", e.d, e.at);
      end
      if (rdy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: got rdy with dat %0h in cycle %0d, want none", dat, cyc);
        end else begin
          e = q.pop_front();
          check("rdy_cycle", 32'(cyc), 32'(e.at));
          check("dat", 32'(dat), 32'(e.d));
          check("nsamp", 32'(nsamp), 32'(e.n));
        end
        check("rdy_single_cycle", 32'(rdy_prev), 32'd0);
        gap = cyc - last_rdy;
        last_rdy = cyc;
        rdy_cnt++;
      end
      rdy_prev = rdy;
      if (adc_convst) begin
        convst_cnt++;
        check("convst_phase", 32'((cyc - rise) % DIV), 32'(DIV - 1));
        check("convst_req", 32'(req_e), 32'd1);
        check("convst_busy", 32'(adc_busy), 32'd0);
      end
      check("err", 32'(err), 32'(err_exp));
    end
  end

  task automatic wait_convst(input string name, input int max, output int n);
    n = 0;
    while (n < max) begin
      @(negedge clk);
      n++;
      if (adc_convst) break;
    end
    if (!adc_convst) fail_timeout(name);
  endtask

  task automatic wait_rdys(input string name, input int target, input int max);
    int n;
    n = 0;
    while (rdy_cnt < target && n < max) begin
      @(negedge clk);
      n++;
    end
    if (rdy_cnt < target) fail_timeout(name);
  endtask

  function automatic int expected_gap(input int d, input int l);
    return DIV * ((d + l + 3 + DIV - 1) / DIV);
  endfunction

  initial begin
    int n;
    int base;
    reset = 1'b1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_rdy", 32'(rdy), 32'd0);
    check("reset_dat", 32'(dat), 32'd0);
    check("reset_convst", 32'(adc_convst), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_nsamp", 32'(nsamp), 32'd0);

    // Basic: first convst on the DIV-th cycle, then four samples 16 cycles apart
    @(negedge clk);
    req = 1'b1;
    wait_convst("first_convst", 40, n);
    check("first_convst_latency", 32'(n), 32'(DIV));
    wait_rdys("basic_rdys", 4, 120);
    check("basic_nsamp", 32'(nsamp), 32'd4);
    check("basic_gap", 32'(gap), 32'(expected_gap(2, 5)));

    // Dropout while busy: conversion completes silently, no further convst
    n = 0;
    while (!adc_busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!adc_busy) fail_timeout("dropout_busy");
    repeat (2) @(negedge clk);
    req = 1'b0;
    base = convst_cnt;
    repeat (40) @(negedge clk);
    check("dropout_dat", 32'(dat), 32'h9B);
    check("dropout_no_convst", 32'(convst_cnt), 32'(base));

    // Timeout: busy never rises, abort after the timer expires, err sticks
    never = 1'b1;
    base = rdy_cnt;
    req = 1'b1;
    wait_convst("timeout_convst", 40, n);
    n = 0;
    while (!err && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_latency", 32'(n), 32'(TO + 1));
    wait_convst("timeout_next_convst", 40, n);
    check("timeout_err_held", 32'(err), 32'd1);
    repeat (70) @(negedge clk);
    req = 1'b0;
    repeat (20) @(negedge clk);
    check("timeout_no_rdy", 32'(rdy_cnt), 32'(base));
    never = 1'b0;

    // Slow ADC: ticks during a long conversion are lost
    len_cfg = 20;
    base = rdy_cnt;
    req = 1'b1;
    wait_rdys("slow_rdys", base + 3, 200);
    check("slow_gap", 32'(gap), 32'(expected_gap(2, 20)));
    req = 1'b0;
    repeat (50) @(negedge clk);
    len_cfg = 5;

    // Reset during WAIT_HI
    req = 1'b1;
    wait_convst("reset_convst_wait", 40, n);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 1'b0;
    check("midreset_rdy", 32'(rdy), 32'd0);
    check("midreset_dat", 32'(dat), 32'd0);
    check("midreset_convst", 32'(adc_convst), 32'd0);
    check("midreset_err", 32'(err), 32'd0);
    check("midreset_nsamp", 32'(nsamp), 32'd0);
    base = rdy_cnt;
    repeat (30) @(negedge clk);
    check("midreset_no_rdy", 32'(rdy_cnt), 32'(base));

    // Wrap of the sample counter
    force dut.nsamp = 16'hFFFF;
    nsamp_model = 16'hFFFF;
    #1;
    release dut.nsamp;
    @(negedge clk);
    base = rdy_cnt;
    req = 1'b1;
    wait_rdys("wrap_rdy", base + 1, 60);
    check("wrap_nsamp", 32'(nsamp), 32'd0);
    check("wrap_err", 32'(err), 32'd0);
    req = 1'b0;
    repeat (30) @(negedge clk);

    // Randomised ADC timing and req dropouts
    for (int it = 0; it < 12; it++) begin
      int on_cycles;
      delay_cfg = $urandom_range(1, 4);
      len_cfg = $urandom_range(1, 30);
      on_cycles = $urandom_range(20, 150);
      req = 1'b1;
      for (int t = 0; t < on_cycles; t++) begin
        @(negedge clk);
        if ($urandom_range(0, 29) == 0) req = ~req;
      end
      req = 1'b0;
      repeat (50) @(negedge clk);
    end

    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
